fifo_rd_stream: RTL
===================

// Module: fifo_rd_stream
// PURPOSE
//  Read-side consumer for the team's dual-clock FIFO. Lives in the rd_clk domain,
//  drives rd_en, captures the registered data_out and presents it as a
//  valid/ready stream to downstream logic.
//  Holds a 2-entry output buffer to sustain 1 word/cycle across the FIFO's 1-cycle read latency.
//  Start/stop FSM drains cleanly; rd_en is never issued while fifo_empty=1.
// PARAMETERS
//  D_WIDTH  8   data word width; must match the FIFO d_width
//  CNT_W    16  width of the delivered-word counter
// PORTS
//  rd_clk      in   1        read-domain clock; all logic on posedge
//  rd_rst      in   1        asynchronous, active-low reset
//  enable      in   1        level; 1 = fetch from FIFO, 0 = stop fetching and drain
//  fifo_empty  in   1        FIFO empty flag, rd_clk domain
//  fifo_data   in   D_WIDTH  FIFO data_out; valid the cycle after rd_en
//  rd_en       out  1        FIFO read strobe
//  m_valid     out  1        stream word valid
//  m_data      out  D_WIDTH  stream word (buffer head)
//  m_ready     in   1        downstream accept
//  busy        out  1        FSM not IDLE
//  drain_done  out  1        1-cycle pulse when DRAIN reaches empty
//  word_cnt    out  CNT_W    words accepted downstream (m_valid&m_ready); wraps
// BEHAVIOUR
//  Reset (rd_rst=0, async): rd_en=0, m_valid=0, m_data=0, busy=0, drain_done=0,
//   word_cnt=0. Buffer count=0, in_flight=0, FSM=IDLE. Takes effect immediately.
//  pop = m_valid & m_ready. A word on fifo_data lands in the buffer at the edge
//   after its rd_en (in_flight=1 for that cycle).
//  rd_en = (state==RUN) & ~fifo_empty & (count + in_flight - pop < 2).
//   Combinational path m_ready->rd_en is intentional. Gives full throughput
//   with count=1, in_flight=1, pop=1.
//  Buffer: FIFO order. m_data = oldest entry; m_valid = (count!=0).
//   Simultaneous land+pop: count unchanged, order kept. Overflow impossible by the rd_en rule.
//  m_data/m_valid hold stable while m_valid & ~m_ready.
//  FSM:
//   IDLE  -> RUN when enable=1.
//   RUN   -> DRAIN when enable=0. A rd_en issued in the same cycle still lands.
//   DRAIN: no rd_en. Buffer delivers normally.
//    -> IDLE when count=0 & in_flight=0; drain_done=1 on that transition edge.
//    -> RUN if enable returns to 1 before then; no drain_done.
//  busy = (state!=IDLE).
//  fifo_empty=1: no rd_en; the stream drains the buffer, then m_valid=0.
//  word_cnt increments on pop and wraps 2^CNT_W-1 -> 0.
//  Reset mid-operation: buffered and in-flight words are discarded. A fifo_data
//   return after reset is ignored.
// STRUCTURE
//  fifo_pkg: D_WIDTH default; typedef enum {IDLE,RUN,DRAIN} rd_state_t.
//  Sub-module fifo_rd_skid: 2-entry buffer with push/pop/count, rd_clk/rd_rst.
//  Top holds FSM, in_flight flag, rd_en logic, word_cnt.
// TESTING
//  1 FIFO preloaded 0x11..0x18, enable=1, m_ready=1 -> rd_en on 8 consecutive
//    cycles; m_data 0x11..0x18 on consecutive cycles from 2 cycles after first rd_en;
//    word_cnt=8.
//  2 m_ready=0 with 8 words available -> exactly 2 rd_en issued, m_valid=1 and
//    m_data=0x11 held stable; m_ready=1 -> 0x12, 0x13... with no loss or duplicates.
//  3 fifo_empty=1 throughout, enable=1 -> rd_en never asserted, m_valid=0.
//    Push one word 0x5A -> single rd_en, m_data=0x5A.
//  4 enable 1->0 with count=1, in_flight=1 -> no further rd_en; 2 words delivered;
//    drain_done pulses once; busy=0 the next cycle.
//  5 rd_rst low mid-stream with count=2 -> all outputs 0 immediately;
//    post-reset fifo_data ignored. Re-enable resumes from the next FIFO word.
//  6 CNT_W=4, 17 pops -> word_cnt wraps 15->0 and reads 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the dual-clock FIFO read-side consumer.
package fifo_pkg;
  localparam int D_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order output buffer; entry 0 is always the oldest word.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic               rd_clk,
  input  logic               rd_rst,
  input  logic               i_push,
  input  logic [D_WIDTH-1:0] i_push_data,
  input  logic               i_pop,
  output logic [1:0]         o_count,
  output logic [D_WIDTH-1:0] o_head
);

  logic [D_WIDTH-1:0] r_ent0;
  logic [D_WIDTH-1:0] r_ent1;
  logic [1:0]         r_count;

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      r_ent0  <= '0;
      r_ent1  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == 2'd0) r_ent0 <= i_push_data;
          else                 r_ent1 <= i_push_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_ent0  <= r_ent1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Land and pop together: occupancy unchanged, new word goes to the tail.
          if (r_count == 2'd2) begin
            r_ent0 <= r_ent1;
            r_ent1 <= i_push_data;
          end else begin
            r_ent0 <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_ent0;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side consumer: issues rd_en, absorbs the 1-cycle read latency in a
// 2-entry buffer and presents the words as a valid/ready stream.
//
// state | meaning
// IDLE  | not fetching, buffer empty
// RUN   | fetching from FIFO while buffer has room
// DRAIN | no new fetches; delivering buffered and in-flight words
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int CNT_W   = 16
) (
  input  logic               rd_clk,
  input  logic               rd_rst,
  input  logic               enable,
  input  logic               fifo_empty,
  input  logic [D_WIDTH-1:0] fifo_data,
  output logic               rd_en,
  output logic               m_valid,
  output logic [D_WIDTH-1:0] m_data,
  input  logic               m_ready,
  output logic               busy,
  output logic               drain_done,
  output logic [CNT_W-1:0]   word_cnt
);

  rd_state_t          r_state;
  rd_state_t          w_next;
  logic               r_in_flight;
  logic [CNT_W-1:0]   r_word_cnt;
  logic [1:0]         w_count;
  logic [D_WIDTH-1:0] w_head;
  logic               w_pop;
  logic [2:0]         w_occ;
  logic               w_drained;

  fifo_rd_skid #(.D_WIDTH(D_WIDTH)) u_skid (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .i_push      (r_in_flight),
    .i_push_data (fifo_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  assign m_valid = (w_count != 2'd0);
  assign m_data  = w_head;
  assign w_pop   = m_valid & m_ready;
  // Occupancy after this cycle; counting the pop lets rd_en sustain 1 word/cycle.
  assign w_occ     = {1'b0, w_count} + {2'b00, r_in_flight} - {2'b00, w_pop};
  assign w_drained = (w_count == 2'd0) & ~r_in_flight;

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_next = RUN;
      RUN:     if (!enable) w_next = DRAIN;
      DRAIN: begin
        if (enable)         w_next = RUN;
        else if (w_drained) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    rd_en      = 1'b0;
    busy       = 1'b0;
    drain_done = 1'b0;
    rd_en      = (r_state == RUN) & ~fifo_empty & (w_occ < 3'd2);
    busy       = (r_state != IDLE);
    drain_done = (r_state == DRAIN) & ~enable & w_drained;
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      r_in_flight <= 1'b0;
      r_word_cnt  <= '0;
    end else begin
      r_in_flight <= rd_en;
      if (w_pop) r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  assign word_cnt = r_word_cnt;

endmodule
